// File: rtl/frame_pcie_buf_pkg.sv
// Shared constants and read-FSM state type for the
// frame-to-PCIe ping-pong buffer controller.
package frame_pcie_buf_pkg;

  localparam int PIX_W      = 16;
  localparam int WORD_W     = 128;
  localparam int WR_AW      = 12;
  localparam int RD_AW      = 9;
  localparam int HALF_PIX   = 2048;
  localparam int HALF_WORDS = 256;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    STREAM
  } rd_state_t;

endpackage

// File: rtl/frame_pcie_rd_skid.sv
// 2-entry FIFO between the RAM read port and the TX stream.
// Ports: push/push_data in, pop in, head out, count out.
module frame_pcie_rd_skid
  import frame_pcie_buf_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wptr;
  logic         rptr;

  assign head = rptr ? mem1 : mem0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0  <= '0;
      mem1  <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        if (wptr) mem1 <= push_data;
        else      mem0 <= push_data;
        wptr <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/frame_pcie_buf_ctrl.sv
// Ping-pong controller: packs pixels into two RAM halves and
// streams each full half to the DMA as 128-bit words.
// Ports: pix_* in, ram_wr_*/ram_rd_* RAM, dma_* req/ack,
// tx_* word stream, half_full status.
module frame_pcie_buf_ctrl
  import frame_pcie_buf_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              pix_sof,
  output logic              ram_wr_en,
  output logic [WR_AW-1:0]  ram_wr_addr,
  output logic [PIX_W-1:0]  ram_wr_data,
  output logic [RD_AW-1:0]  ram_rd_addr,
  input  logic [WORD_W-1:0] ram_rd_data,
  output logic              dma_req,
  output logic              dma_half,
  input  logic              dma_ack,
  output logic [WORD_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic [1:0]        half_full
);

  // write side
  logic             wr_sel;
  logic [WR_AW-2:0] wcnt;
  logic [WR_AW-2:0] widx;
  logic             accept;
  logic             wr_done;

  assign pix_ready = ~half_full[wr_sel];
  assign accept    = pix_valid & pix_ready;
  // sof restarts the half at index 0
  assign widx      = pix_sof ? '0 : wcnt;
  assign wr_done   = accept &
                     (widx == (WR_AW-1)'(HALF_PIX-1));

  assign ram_wr_en   = accept;
  assign ram_wr_addr = accept ? {wr_sel, widx} : '0;
  assign ram_wr_data = accept ? pix_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_sel <= 1'b0;
      wcnt   <= '0;
    end else if (accept) begin
      if (wr_done) begin
        wr_sel <= ~wr_sel;
        wcnt   <= '0;
      end else begin
        wcnt <= widx + 1'b1;
      end
    end
  end

  // read side
  rd_state_t        state;
  logic             rd_sel;
  logic [RD_AW-1:0] rcnt;
  logic [7:0]       ocnt;
  logic             in_flight;
  logic [1:0]       fcount;
  logic [2:0]       occ;
  logic             pop;
  logic             issue;
  logic             rd_done;
  logic [1:0]       hf_set;
  logic [1:0]       hf_clr;

  assign tx_valid = (fcount != 2'd0);
  assign tx_last  = tx_valid &
                    (ocnt == 8'(HALF_WORDS-1));
  assign pop      = tx_valid & tx_ready;
  assign rd_done  = pop & tx_last;

  // words buffered or still coming back from the RAM
  assign occ   = 3'(fcount) + 3'(in_flight);
  assign issue = (state == STREAM) &
                 (rcnt != RD_AW'(HALF_WORDS)) &
                 (occ < 3'd2 + 3'(pop));

  assign ram_rd_addr = {rd_sel, rcnt[RD_AW-2:0]};

  assign hf_set = {wr_done & wr_sel, wr_done & ~wr_sel};
  assign hf_clr = {rd_done & rd_sel, rd_done & ~rd_sel};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) half_full <= 2'b00;
    else     half_full <= (half_full & ~hf_clr) | hf_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rd_sel    <= 1'b0;
      rcnt      <= '0;
      ocnt      <= '0;
      in_flight <= 1'b0;
      dma_req   <= 1'b0;
      dma_half  <= 1'b0;
    end else begin
      in_flight <= issue;
      if (issue) rcnt <= rcnt + 1'b1;
      if (pop)   ocnt <= ocnt + 1'b1;
      unique case (state)
        IDLE: begin
          if (half_full[rd_sel]) begin
            state    <= REQ;
            dma_req  <= 1'b1;
            dma_half <= rd_sel;
          end
        end
        REQ: begin
          if (dma_ack) begin
            state    <= STREAM;
            dma_req  <= 1'b0;
            dma_half <= 1'b0;
          end
        end
        STREAM: begin
          if (rd_done) begin
            state  <= IDLE;
            rd_sel <= ~rd_sel;
            rcnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  frame_pcie_rd_skid #(.W(WORD_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_data (ram_rd_data),
    .pop       (pop),
    .head      (tx_data),
    .count     (fcount)
  );

endmodule

// File: tb/tb_frame_pcie_buf_ctrl.sv
// Randomized bench for frame_pcie_buf_ctrl with a RAM model
// and a pixel-array/word-queue reference model.
module tb_frame_pcie_buf_ctrl;
  import frame_pcie_buf_pkg::*;

  logic         clk;
  logic         rst;
  logic [15:0]  pix_data;
  logic         pix_valid;
  logic         pix_ready;
  logic         pix_sof;
  logic         ram_wr_en;
  logic [11:0]  ram_wr_addr;
  logic [15:0]  ram_wr_data;
  logic [8:0]   ram_rd_addr;
  logic [127:0] ram_rd_data;
  logic         dma_req;
  logic         dma_half;
  logic         dma_ack;
  logic [127:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;
  logic [1:0]   half_full;

  frame_pcie_buf_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_sof     (pix_sof),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_addr (ram_rd_addr),
    .ram_rd_data (ram_rd_data),
    .dma_req     (dma_req),
    .dma_half    (dma_half),
    .dma_ack     (dma_ack),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_last     (tx_last),
    .half_full   (half_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SDPRAM: 16-bit write view, 128-bit registered read view
  logic [15:0]  ram [4096];
  logic [127:0] rd_q;
  assign ram_rd_data = rd_q;
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    for (int k = 0; k < 8; k++)
      rd_q[16*k +: 16] <= ram[{ram_rd_addr, 3'(k)}];
  end

  int n_tests;
  int n_fail;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // reference model
  logic [1:0]   m_full;
  bit           m_wsel;
  bit           m_rsel;
  int           m_wcnt;
  int           m_beat;
  logic [15:0]  m_pix [2][2048];
  logic [127:0] exp_q [$];
  logic [127:0] first_word;
  logic [127:0] last_word;
  int           beats_total;
  bit           hold_v;
  logic [127:0] hold_d;
  logic         hold_l;

  always @(negedge clk) begin
    int idx;
    logic [127:0] w;
    if (rst) begin
      m_full = 2'b00;
      m_wsel = 0;
      m_rsel = 0;
      m_wcnt = 0;
      m_beat = 0;
      hold_v = 0;
      exp_q.delete();
    end else begin
      check("pix_ready", pix_ready, !m_full[m_wsel]);
      check("half_full", half_full, m_full);
      if (hold_v) begin
        check("stall_valid", tx_valid, 1'b1);
        check("stall_data", tx_data, hold_d);
        check("stall_last", tx_last, hold_l);
      end
      hold_v = tx_valid && !tx_ready;
      hold_d = tx_data;
      hold_l = tx_last;
      if (dma_req) check("dma_half", dma_half, m_rsel);
      if (pix_valid && !m_full[m_wsel]) begin
        idx = pix_sof ? 0 : m_wcnt;
        check("wr_en", ram_wr_en, 1'b1);
        check("wr_addr", ram_wr_addr, {m_wsel, 11'(idx)});
        check("wr_data", ram_wr_data, pix_data);
        m_pix[m_wsel][idx] = pix_data;
        if (idx == HALF_PIX - 1) begin
          for (int j = 0; j < HALF_WORDS; j++) begin
            for (int k = 0; k < 8; k++)
              w[16*k +: 16] = m_pix[m_wsel][j*8 + k];
            exp_q.push_back(w);
          end
          m_full[m_wsel] = 1'b1;
          m_wsel = !m_wsel;
          m_wcnt = 0;
        end else begin
          m_wcnt = idx + 1;
        end
      end else begin
        check("wr_en_idle", ram_wr_en, 1'b0);
      end
      if (tx_valid && tx_ready) begin
        check("tx_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0)
          check("tx_data", tx_data, exp_q.pop_front());
        check("tx_last", tx_last, m_beat == 255);
        if (m_beat == 0)   first_word = tx_data;
        if (m_beat == 255) last_word = tx_data;
        beats_total++;
        if (m_beat == 255) begin
          m_full[m_rsel] = 1'b0;
          m_rsel = !m_rsel;
          m_beat = 0;
        end else begin
          m_beat++;
        end
      end
    end
  end

  // DMA ack and TX ready drivers
  bit auto_ack;
  bit manual_ack;
  int ack_delay;
  int ready_mode;

  always @(posedge clk) begin
    #1;
    if (dma_req && auto_ack) begin
      if (ack_delay == 0) begin
        dma_ack = 1'b1;
        ack_delay = $urandom_range(0, 3);
      end else begin
        dma_ack = 1'b0;
        ack_delay--;
      end
    end else begin
      dma_ack = manual_ack |
                (!dma_req && ($urandom_range(0, 7) == 0));
    end
  end

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      default: tx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic [11:0] last_addr;
  logic [11:0] sof_addr;

  task automatic write_px(input int n, input int sof_at,
                          input bit idx_data, input int gap);
    bit ok;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gap > 0) begin
        pix_valid = 1'b0;
        repeat ($urandom_range(0, gap)) begin
          @(posedge clk);
          #1;
        end
      end
      pix_valid = 1'b1;
      pix_data  = idx_data ? 16'(i) : 16'($urandom);
      pix_sof   = (i == sof_at);
      t = 0;
      do begin
        @(negedge clk);
        ok = pix_ready;
        if (ok) begin
          last_addr = ram_wr_addr;
          if (pix_sof) sof_addr = ram_wr_addr;
        end
        @(posedge clk);
        #1;
        t++;
      end while (!ok && t < 4000);
      if (!ok) begin
        check("px_timeout", ok, 1'b1);
        break;
      end
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(m_full == 0 && exp_q.size() == 0 &&
                 !tx_valid) && t < 20000);
    check({tag, "_drained"},
          (m_full == 0) && (exp_q.size() == 0), 1'b1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_pix_ready"}, pix_ready, 1'b1);
    check({tag, "_dma_req"}, dma_req, 1'b0);
    check({tag, "_dma_half"}, dma_half, 1'b0);
    check({tag, "_tx_valid"}, tx_valid, 1'b0);
    check({tag, "_tx_last"}, tx_last, 1'b0);
    check({tag, "_tx_data"}, tx_data, 128'd0);
    check({tag, "_half_full"}, half_full, 2'b00);
    check({tag, "_wr_en"}, ram_wr_en, 1'b0);
    check({tag, "_rd_addr"}, ram_rd_addr, 9'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] e0;
    logic [127:0] e255;
    int run;
    int b0;
    int t;
    n_tests = 0;
    n_fail = 0;
    beats_total = 0;
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_data = '0;
    tx_ready = 1'b1;
    dma_ack = 1'b0;
    auto_ack = 0;
    manual_ack = 0;
    ack_delay = 0;
    ready_mode = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single half, value = index, manual ack
    write_px(2048, -1, 1, 0);
    @(negedge clk);
    check("s_half_full", half_full, 2'b01);
    check("s_req_early", dma_req, 1'b0);
    @(negedge clk);
    check("s_req", dma_req, 1'b1);
    check("s_req_half", dma_half, 1'b0);
    manual_ack = 1;
    @(negedge clk);
    manual_ack = 0;
    @(negedge clk);
    check("s_lat1", tx_valid, 1'b0);
    @(negedge clk);
    check("s_lat2", tx_valid, 1'b0);
    @(negedge clk);
    check("s_lat3", tx_valid, 1'b1);
    run = tx_valid ? 1 : 0;
    repeat (255) begin
      @(negedge clk);
      if (tx_valid) run++;
    end
    check("s_burst", run, 256);
    wait_idle("single");
    for (int k = 0; k < 8; k++) begin
      e0[16*k +: 16] = 16'(k);
      e255[16*k +: 16] = 16'(2040 + k);
    end
    check("s_word0", first_word, e0);
    check("s_word255", last_word, e255);
    check("s_after", half_full, 2'b00);

    // both halves full, no ack until the stall is seen
    do_reset();
    write_px(4096, -1, 0, 2);
    @(negedge clk);
    check("b_full", half_full, 2'b11);
    check("b_stall", pix_ready, 1'b0);
    repeat (5) @(negedge clk);
    check("b_req", dma_req, 1'b1);
    check("b_req_half", dma_half, 1'b0);
    auto_ack = 1;
    ready_mode = 2;
    write_px(1, -1, 0, 0);
    check("b_px4096_addr", last_addr, 12'h000);
    write_px(2047, -1, 0, 2);
    wait_idle("both");

    // backpressure 1-0
    ready_mode = 1;
    b0 = beats_total;
    write_px(2048, -1, 0, 2);
    wait_idle("bp");
    check("bp_beats", beats_total - b0, 256);

    // frame restart at pixel 1000
    do_reset();
    ready_mode = 2;
    write_px(3047, 1000, 0, 1);
    check("sof_addr", sof_addr, 12'h000);
    @(negedge clk);
    check("sof_not_full", half_full, 2'b00);
    write_px(1, -1, 0, 0);
    @(negedge clk);
    check("sof_full", half_full, 2'b01);
    wait_idle("sof");

    // reset at word 100 of a stream
    do_reset();
    ready_mode = 0;
    write_px(2048, -1, 0, 1);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (m_beat != 100 && t < 2000);
    check("mid_reached", m_beat, 100);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outs("mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    b0 = beats_total;
    write_px(2048, -1, 0, 1);
    wait_idle("mid");
    check("mid_beats", beats_total - b0, 256);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
